// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan driver.
//   SEG_* : active-high segment codes, bit order {g,f,e,d,c,b,a}
//   bcd_to_seg : 4-bit code -> segment pattern (10..15 render as a dash)
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD to 7-segment decoder (active-high).
//   bcd : 4-bit digit code
//   seg : segments {g,f,e,d,c,b,a}
module seg7_bcd_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with leading-zero blanking, blink and enable.
//   clk, rst_n : clock, async active-low reset
//   en         : scan enable (0 freezes counters and turns all anodes off)
//   load       : capture digits_in into the shadow register
//   digits_in  : BCD digits, digit k at [4k+3:4k]
//   blank_lz   : blank leading zero digits (digit 0 is never blanked)
//   blink_en   : gate anodes with the blink phase
//   seg_out    : segments {g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//   an_out     : one-hot digit select, polarity per AN_ACT_LOW
//   frame_tick : one-cycle pulse on scan wrap from digit N-1 to 0
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter bit          SEG_ACT_LOW  = 1'b0,
    parameter bit          AN_ACT_LOW   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_tick
);

    localparam int unsigned DivW   = $clog2(SCAN_DIV);
    localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
    localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DivW-1:0]   DivLast   = DivW'(SCAN_DIV - 1);
    localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NUM_DIGITS - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    // Copy of the shadow actually shown; only refreshed at digit boundaries so a
    // load never changes the digit currently being driven.
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [DivW-1:0]         div_q, div_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [BlinkW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                    blink_on_q, blink_on_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    tick_q, tick_d;

    logic                    advance, wrap;
    logic [3:0]              cur_digit;
    logic [6:0]              dec_seg;
    logic                    upper_nz;
    logic                    lz_blank;

    // Counters and shadow next-state
    always_comb begin
        advance     = en && (div_q == DivLast);
        wrap        = advance && (idx_q == IdxLast);

        div_d       = div_q;
        idx_d       = idx_q;
        if (en) begin
            div_d = advance ? '0 : div_q + 1'b1;
        end
        if (advance) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end

        shadow_d    = load ? digits_in : shadow_q;
        // While stopped nothing is on screen, so the display copy may follow freely.
        disp_d      = (advance || !en) ? shadow_d : disp_q;

        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (wrap) begin
            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
        tick_d      = wrap;
    end

    // Digit mux and leading-zero detection on the displayed copy
    always_comb begin
        cur_digit = 4'd0;
        upper_nz  = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IdxW'(k)) begin
                cur_digit = disp_q[4*k +: 4];
            end
            if ((IdxW'(k) >= idx_q) && (disp_q[4*k +: 4] != 4'd0)) begin
                upper_nz = 1'b1;
            end
        end
        lz_blank = blank_lz && (idx_q != '0) && !upper_nz;
    end

    seg7_bcd_decode u_decode (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    // Output next-state in priority order: disabled, blink-off, blanked, normal
    always_comb begin
        seg_d        = SEG_BLANK;
        an_d         = '0;
        if (!en) begin
            seg_d = SEG_BLANK;
        end else if (blink_en && !blink_on_q) begin
            seg_d = dec_seg;
        end else if (lz_blank) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d        = dec_seg;
            an_d[idx_q]  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            disp_q      <= '0;
            div_q       <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            seg_q       <= SEG_BLANK;
            an_q        <= '0;
            tick_q      <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            disp_q      <= disp_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            tick_q      <= tick_d;
        end
    end

    assign seg_out    = seg_q ^ {7{SEG_ACT_LOW}};
    assign an_out     = an_q ^ {NUM_DIGITS{AN_ACT_LOW}};
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: an active-high and an active-low instance
// share the same stimulus; expected patterns are hand-written constants.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic        blank_lz;
    logic        blink_en;
    logic [6:0]  seg_out, seg_inv;
    logic [3:0]  an_out, an_inv;
    logic        frame_tick, frame_tick_inv;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2),
        .SEG_ACT_LOW  (1'b0),
        .AN_ACT_LOW   (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .digits_in  (digits_in),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_tick (frame_tick)
    );

    seg7_scan_driver #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2),
        .SEG_ACT_LOW  (1'b1),
        .AN_ACT_LOW   (1'b1)
    ) dut_inv (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .digits_in  (digits_in),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .seg_out    (seg_inv),
        .an_out     (an_inv),
        .frame_tick (frame_tick_inv)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Check both instances right now against one active-high expectation.
    task automatic check_outputs(input string tag, input logic [6:0] eseg, input logic [3:0] ean,
                                 input logic etick);
        logic [6:0] iseg;
        logic [3:0] ian;
        iseg = ~eseg;
        ian  = ~ean;
        check_eq({tag, "/an"}, an_out, ean);
        check_eq({tag, "/seg"}, seg_out, eseg);
        check_eq({tag, "/tick"}, frame_tick, etick);
        check_eq({tag, "/an_inv"}, an_inv, ian);
        check_eq({tag, "/seg_inv"}, seg_inv, iseg);
        check_eq({tag, "/tick_inv"}, frame_tick_inv, etick);
    endtask

    // Step nsteps clocks, expecting a constant pattern; tick only on the last step if asked.
    task automatic expect_slot(input string tag, input int nsteps, input logic [6:0] eseg,
                               input logic [3:0] ean, input logic tick_last);
        for (int s = 0; s < nsteps; s++) begin
            @(negedge clk);
            check_outputs(tag, eseg, ean, tick_last && (s == nsteps - 1));
        end
    endtask

    // One full frame; eseg/ean hold per-digit expectations, digit 0 in the low bits.
    task automatic check_frame(input string tag, input logic [31:0] eseg, input logic [15:0] ean);
        for (int d = 0; d < 4; d++) begin
            expect_slot(tag, 4, eseg[8*d +: 7], ean[4*d +: 4], d == 3);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        blank_lz = 1'b0;
        blink_en = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    // Load while stopped, then start scanning from the current position.
    task automatic load_and_start(input logic [15:0] val, input logic lz, input logic blink);
        load      = 1'b1;
        digits_in = val;
        blank_lz  = lz;
        blink_en  = blink;
        en        = 1'b0;
        @(negedge clk);
        load = 1'b0;
        en   = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0000;
        blank_lz  = 1'b0;
        blink_en  = 1'b0;
        #1;
        check_outputs("reset0", 7'h00, 4'b0000, 1'b0);

        // Basic scan of 1234, two frames
        do_reset();
        load_and_start(16'h1234, 1'b0, 1'b0);
        check_frame("scan_f0", 32'h065B4F66, 16'h8421);
        check_frame("scan_f1", 32'h065B4F66, 16'h8421);

        // Async reset while frame_tick is high, then restart at digit 0 with cleared shadow
        #2 rst_n = 1'b0;
        #1;
        check_outputs("rst_mid", 7'h00, 4'b0000, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        expect_slot("rst_idx0", 4, 7'h3F, 4'b0001, 1'b0);
        expect_slot("rst_idx1", 4, 7'h3F, 4'b0010, 1'b0);

        // Leading-zero blanking
        do_reset();
        load_and_start(16'h0050, 1'b1, 1'b0);
        check_frame("lz_0050", 32'h00006D3F, 16'h0021);
        do_reset();
        load_and_start(16'h0000, 1'b1, 1'b0);
        check_frame("lz_0000", 32'h0000003F, 16'h0001);

        // Codes above 9 render as a dash
        do_reset();
        load_and_start(16'hFA3A, 1'b0, 1'b0);
        check_frame("dash", 32'h40404F40, 16'h8421);

        // Blink: 2 frames on, 2 off (segments keep decoding), then on again
        do_reset();
        load_and_start(16'h1234, 1'b0, 1'b1);
        check_frame("blink_on0", 32'h065B4F66, 16'h8421);
        check_frame("blink_on1", 32'h065B4F66, 16'h8421);
        check_frame("blink_off0", 32'h065B4F66, 16'h0000);
        check_frame("blink_off1", 32'h065B4F66, 16'h0000);
        check_frame("blink_on2", 32'h065B4F66, 16'h8421);

        // Freeze mid-slot on digit 1, then resume from the same spot
        blink_en = 1'b0;
        expect_slot("pre_freeze0", 4, 7'h66, 4'b0001, 1'b0);
        expect_slot("pre_freeze1", 2, 7'h4F, 4'b0010, 1'b0);
        en = 1'b0;
        expect_slot("frozen", 10, 7'h00, 4'b0000, 1'b0);
        en = 1'b1;
        expect_slot("resume1", 2, 7'h4F, 4'b0010, 1'b0);
        expect_slot("resume2", 4, 7'h5B, 4'b0100, 1'b0);
        expect_slot("resume3", 4, 7'h06, 4'b1000, 1'b1);
        expect_slot("resume0", 4, 7'h66, 4'b0001, 1'b0);

        // Mid-slot load keeps the current digit; next slot shows the new value
        do_reset();
        load_and_start(16'h1234, 1'b0, 1'b0);
        expect_slot("midload_a", 2, 7'h66, 4'b0001, 1'b0);
        load      = 1'b1;
        digits_in = 16'h9999;
        expect_slot("midload_b", 1, 7'h66, 4'b0001, 1'b0);
        load = 1'b0;
        expect_slot("midload_c", 1, 7'h66, 4'b0001, 1'b0);
        expect_slot("midload_d1", 4, 7'h6F, 4'b0010, 1'b0);
        expect_slot("midload_d2", 4, 7'h6F, 4'b0100, 1'b0);
        expect_slot("midload_d3", 3, 7'h6F, 4'b1000, 1'b0);
        // Load coinciding with the wrap edge: the new digit 0 uses the new value
        load      = 1'b1;
        digits_in = 16'h1234;
        expect_slot("edgeload_d3", 1, 7'h6F, 4'b1000, 1'b1);
        load = 1'b0;
        expect_slot("edgeload_d0", 4, 7'h66, 4'b0001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
